// File: rtl/seg_pair_encoder.sv
// seg_pair_encoder
//   Converts a 7-bit binary value to two seven-segment digits (tens, ones).
//   A bit-serial double-dabble engine builds the BCD digits. The result is then
//   encoded and held in a register that feeds the two-digit display multiplexer.
//
//   Parameter
//     SEG_INVERT  0: segments are active-high; 1: every output bit is inverted
//                 (common-anode displays)
//   Optional build macro
//     LEADING_ZERO_BLANK_EN  blanks the tens digit when it is 0 and err is 0
//   Ports
//     clk       rising-edge clock
//     rst       synchronous reset, active low
//     start     conversion request (only taken in IDLE)
//     value     binary value, latched together with start
//     busy      high while a conversion is running
//     done      one-cycle pulse when both7seg is updated
//     err       the last accepted value was > 99 (held until the next result)
//     both7seg  [13:7] tens digit, [6:0] ones digit, bit order a..g = 6..0
module seg_pair_encoder #(
  parameter bit SEG_INVERT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  value,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [13:0] both7seg
);

  typedef enum logic [1:0] {IDLE, CONV, ENC} state_t;

  localparam logic [13:0] INV_MASK = {14{SEG_INVERT}};

  state_t      state;
  logic [6:0]  shreg;
  logic [6:0]  val_lat;
  logic [7:0]  bcd;
  logic [2:0]  cnt;

  logic [3:0]  ones_adj;
  logic [2:0]  tens_adj_lo;
  logic [13:0] pat;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'h7E;
      4'd1:    digit_seg = 7'h30;
      4'd2:    digit_seg = 7'h6D;
      4'd3:    digit_seg = 7'h79;
      4'd4:    digit_seg = 7'h33;
      4'd5:    digit_seg = 7'h5B;
      4'd6:    digit_seg = 7'h5F;
      4'd7:    digit_seg = 7'h70;
      4'd8:    digit_seg = 7'h7F;
      4'd9:    digit_seg = 7'h7B;
      default: digit_seg = 7'h00;
    endcase
  endfunction

  // Double-dabble add-3 correction.  The tens nibble's MSB is shifted out
  // by the following left shift, so only its low 3 bits are kept; those
  // depend only on the low 3 bits of the operands.
  always_comb begin
    ones_adj    = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    tens_adj_lo = (bcd[7:4] >= 4'd5) ? bcd[6:4] + 3'd3 : bcd[6:4];
  end

  // Display pattern, before the inversion mask is applied.
  always_comb begin
    pat = {digit_seg(bcd[7:4]), digit_seg(bcd[3:0])};
`ifdef LEADING_ZERO_BLANK_EN
    if (bcd[7:4] == 4'd0) pat[13:7] = 7'h00;
`else
`endif
    // Out-of-range values show a dash on both digits.
    if (val_lat > 7'd99) pat = {7'h01, 7'h01};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      val_lat  <= '0;
      bcd      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      both7seg <= INV_MASK;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= value;
            val_lat <= value;
            bcd     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          // Shift {bcd, shreg} left by one after the add-3 correction.
          bcd   <= {tens_adj_lo, ones_adj, shreg[6]};
          shreg <= {shreg[5:0], 1'b0};
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd6) state <= ENC;
        end
        ENC: begin
          both7seg <= pat ^ INV_MASK;
          err      <= (val_lat > 7'd99);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg_pair_encoder.md
# seg_pair_encoder

Sequential binary-to-two-digit seven-segment encoder that produces the 14-bit `both7seg` pattern consumed by the two-digit display multiplexer. It accepts a 7-bit binary value on a start strobe and converts it to BCD with a bit-serial double-dabble engine. It then encodes the tens and ones digits into segment patterns and holds the result stable until the next conversion completes. It sits directly upstream of the display multiplexer, and its output register drives that block's `both7seg` input.

## Interface
- `SEG_INVERT`, default 0: 0 means segments are active-high (1 = lit); 1 means every bit of `both7seg` is inverted, for common-anode displays.
- `clk`  input  1  sole clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`; `rst`==0 resets the block.
- `start`  input  1  conversion request, sampled in IDLE only.
- `value`  input  7  binary value to display, sampled together with `start`.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  single-cycle pulse when `both7seg` has been updated.
- `err`  output  1  high when the last accepted value exceeded 99; held until the next completed conversion.
- `both7seg`  output  14  registered pattern: [13:7] = tens digit, [6:0] = ones digit.

## Operation
- Segment bit order within each digit: bit6 = a, bit5 = b, bit4 = c, bit3 = d, bit2 = e, bit1 = f, bit0 = g.
- Digit codes, with SEG_INVERT=0:
  - 0 = 7E, 1 = 30, 2 = 6D, 3 = 79, 4 = 33
  - 5 = 5B, 6 = 5F, 7 = 70, 8 = 7F, 9 = 7B
  - Dash = 01; blank = 00.
- FSM states:
  - IDLE: `start`=1 latches `value` into the shift register, clears the BCD register, zeroes the iteration counter and moves to CONV.
  - CONV: performs one double-dabble step per cycle. First, each BCD nibble ≥5 gets +3. Then the {BCD, shift} register is shifted left by 1. After 7 steps (counter 0..6) the FSM moves to ENC.
  - ENC: writes `both7seg`, `err` and `done` for one cycle, then returns to IDLE.
- Arithmetic:
  - The BCD register is 8 bits (two nibbles); the maximum legal input, 99, fits.
  - Inputs 100..127 yield a tens nibble >9. ENC detects this from the latched `value` (> 99), drives dashes on both digits ({01,01}) and sets `err`=1.
- `start` while `busy` is ignored (no queueing). `value` changes during a conversion do not affect the result.
- `start` held high continuously causes back-to-back conversions. The next one is accepted in the IDLE cycle immediately following ENC.
- Reset (`rst`=0), including mid-conversion, has these results:
  - The FSM goes to IDLE and the conversion in flight is discarded.
  - `busy`=0, `done`=0, `err`=0.
  - `both7seg` = blank on both digits: 14'h0000 with SEG_INVERT=0, 14'h3FFF with SEG_INVERT=1.
- SEG_INVERT is applied as a final XOR on the value written to `both7seg`. It covers the blank and dash patterns too.

## Timing
- `start` sampled high in IDLE at edge N:
  - `busy`=1 from after edge N until edge N+8.
  - The CONV steps occur at edges N+1..N+7.
  - At edge N+8 (ENC), `both7seg` and `err` update, `done`=1 for exactly one cycle, and `busy` falls.
- Latency from the start edge to valid output: 8 cycles. Minimum start-to-start period: 9 cycles.
- `both7seg` changes only at the ENC edge or on reset. Between those it is glitch-free and stable, which the downstream multiplexer relies on.
- `done` and `busy` are never high in the same cycle.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: when the tens digit is 0 and `err`=0, [13:7] is driven blank (00, or 7F when inverted). The ones digit always displays.
- `LEADING_ZERO_BLANK_EN` undefined: the tens digit always shows its numeral, including "0".

## Test plan
- Reset: hold `rst`=0 for 2 cycles → `both7seg`=14'h0000, `busy`=0, `done`=0, `err`=0.
- `value`=42 with a `start` pulse → `done` exactly 8 cycles later, `both7seg`=14'h19ED ({33,6D}), `err`=0. `busy` is high for 8 cycles.
- `value`=7 → 14'h3F70 without the macro; 14'h0070 with `LEADING_ZERO_BLANK_EN`. `value`=0 → 14'h3F7E without the macro; 14'h007E with it.
- `value`=99 → 14'h3DFB. Next, `value`=100 → 14'h0081 with `err`=1. Next, `value`=5 → `err` returns to 0.
- `start` re-pulsed at edge N+3 with `value`=11 during a `value`=42 conversion → ignored; the result is still 14'h19ED and only one `done` pulse occurs.
- `rst`=0 asserted at edge N+4 of a conversion → no `done`, `both7seg` blank, `busy`=0. A new start after release with `value`=64 → 14'h2FB3 ({5F,33}). With SEG_INVERT=1, the same value → 14'h104C.
